fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the execute ALU. Holds the architectural PC, issues one word-fetch request at a time to instruction memory, and presents fetched {instr, pc} to decode through a valid/ready handshake. Consumes the ALU's branch_taken/pc_out as a redirect, which flushes any fetch in flight.

---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, keeps at most one
// instruction-memory request outstanding and hands {instr, pc} to decode
// over a valid/ready handshake. An ALU redirect flushes any fetch in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect target
// raises sticky fetch_misalign and halts fetching until reset).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_req_pc, w_req_pc_nxt;
    logic [31:0] r_if_instr, w_if_instr_nxt;
    logic [31:0] r_if_pc, w_if_pc_nxt;
    logic        r_if_valid, w_if_valid_nxt;
    logic        r_drop, w_drop_nxt;
    logic        w_req_fire;
    logic        w_halt;
    logic        w_bad_target;
    logic [31:0] w_redirect_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        r_misalign, w_misalign_nxt;

    // A misaligned target is trapped rather than fixed up.
    assign w_halt         = r_misalign;
    assign w_bad_target   = (redirect_pc[1:0] != 2'b00);
    assign w_redirect_tgt = redirect_pc;
    assign w_misalign_nxt = r_misalign | (redirect_valid && w_bad_target);
    assign fetch_misalign = r_misalign;
`else
    // Without the trap, the low two target bits are simply cleared.
    assign w_halt         = 1'b0;
    assign w_bad_target   = 1'b0;
    assign w_redirect_tgt = redirect_pc & ~32'h3;
`endif

    assign imem_req_valid = (r_state == S_REQ) && !redirect_valid &&
                            (!r_if_valid || if_ready);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign if_valid = r_if_valid;
    assign if_instr = r_if_instr;
    assign if_pc    = r_if_pc;

    // Next-state and datapath updates; a redirect overrides every other event.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_pc_nxt   = r_req_pc;
        w_if_instr_nxt = r_if_instr;
        w_if_pc_nxt    = r_if_pc;
        w_if_valid_nxt = r_if_valid;
        w_drop_nxt     = r_drop;

        if (w_halt) begin
            w_state_nxt = S_IDLE;
        end else if (redirect_valid) begin
            w_pc_nxt       = w_redirect_tgt;
            w_if_valid_nxt = 1'b0;
            case (r_state)
                S_IDLE: w_state_nxt = S_REQ;
                S_REQ:  w_state_nxt = S_REQ;
                S_WAIT: begin
                    // A response landing with the redirect is itself the stale one.
                    if (imem_resp_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
            if (w_bad_target) begin
                w_drop_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        end else begin
            if (r_if_valid && if_ready) begin
                w_if_valid_nxt = 1'b0;
            end
            case (r_state)
                S_IDLE: w_state_nxt = S_REQ;
                S_REQ: begin
                    if (w_req_fire) begin
                        w_req_pc_nxt = r_pc;
                        w_state_nxt  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        w_state_nxt = S_REQ;
                        if (r_drop) begin
                            w_drop_nxt = 1'b0;
                        end else begin
                            w_if_instr_nxt = imem_resp_data;
                            w_if_pc_nxt    = r_req_pc;
                            w_if_valid_nxt = 1'b1;
                            w_pc_nxt       = r_req_pc + 32'd4;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ready        (if_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misalign  (fetch_misalign)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: a list of fetches in flight plus the decode-side slot.
    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } fetch_t;

    fetch_t      inflight_q[$];
    bit          m_starting = 1'b1;
    logic [31:0] m_pc       = RPC;
    bit          m_vld      = 1'b0;
    logic [31:0] m_instr    = '0;
    logic [31:0] m_ipc      = '0;
    bit          m_halt     = 1'b0;
    bit          m_misalign = 1'b0;

    // Instruction memory stub
    int          mem_cnt    = 0;
    int          mem_lat    = 1;
    logic [31:0] mem_data   = '0;
    bit          data_const = 1'b1;
    bit          spur_en    = 1'b0;
    logic [31:0] req_log[$];

    function automatic bit exp_req_valid();
        return !m_halt && !m_starting && (inflight_q.size() == 0) &&
               !redirect_valid && (!m_vld || if_ready);
    endfunction

    task automatic model_edge(input bit fire);
        fetch_t f;
        if (!rst_n) begin
            inflight_q.delete();
            m_starting = 1'b1;
            m_pc       = RPC;
            m_vld      = 1'b0;
            m_instr    = '0;
            m_ipc      = '0;
            m_halt     = 1'b0;
            m_misalign = 1'b0;
            return;
        end
        if (m_halt) return;
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                m_halt     = 1'b1;
                m_misalign = 1'b1;
                m_vld      = 1'b0;
                m_pc       = redirect_pc;
                inflight_q.delete();
                return;
            end
`endif
            m_pc       = {redirect_pc[31:2], 2'b00};
            m_vld      = 1'b0;
            m_starting = 1'b0;
            if (inflight_q.size() > 0) begin
                if (imem_resp_valid) inflight_q.delete();
                else inflight_q[0].stale = 1'b1;
            end
            return;
        end
        if (m_vld && if_ready) m_vld = 1'b0;
        if (m_starting) begin
            m_starting = 1'b0;
        end else if (inflight_q.size() > 0) begin
            if (imem_resp_valid) begin
                f = inflight_q.pop_front();
                if (!f.stale) begin
                    m_vld   = 1'b1;
                    m_instr = imem_resp_data;
                    m_ipc   = f.pc;
                    m_pc    = f.pc + 32'd4;
                end
            end
        end else if (fire) begin
            f.pc    = m_pc;
            f.stale = 1'b0;
            inflight_q.push_back(f);
        end
    endtask

    // One clock cycle: memory drives its response, outputs are checked at the
    // falling edge, then model and memory advance at the rising edge.
    task automatic step();
        bit erv;
        bit dut_fire;
        imem_resp_valid = (mem_cnt == 1) || (spur_en && ($urandom_range(0, 15) == 0));
        imem_resp_data  = (mem_cnt == 1) ? mem_data : $urandom;
        @(negedge clk);
        erv = exp_req_valid();
        check("req_valid", imem_req_valid, erv);
        check("req_addr", imem_req_addr, m_pc);
        check("if_valid", if_valid, m_vld);
        check("if_instr", if_instr, m_instr);
        check("if_pc", if_pc, m_ipc);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign", fetch_misalign, m_misalign);
`endif
        dut_fire = imem_req_valid && imem_req_ready;
        if (dut_fire) req_log.push_back(imem_req_addr);
        @(posedge clk);
        model_edge(erv && imem_req_ready);
        if (mem_cnt > 0) mem_cnt--;
        if (dut_fire) begin
            mem_cnt  = mem_lat;
            mem_data = data_const ? 32'h0000_0013 : $urandom;
        end
        #1;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp);
        int n0;
        n0 = req_log.size();
        for (int i = 0; i < 20 && req_log.size() == n0; i++) step();
        check({tag, "_issued"}, req_log.size(), n0 + 1);
        if (req_log.size() > n0) check(tag, req_log[req_log.size() - 1], exp);
    endtask

    initial begin
        int cyc;
        int n0;

        // Reset
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;

        // Cold start: first instruction lands three cycles after reset release
        for (cyc = 1; cyc <= 10; cyc++) begin
            step();
            if (if_valid) break;
        end
        check("first_vld_cycle", cyc, 3);
        check("first_pc", if_pc, 32'h0);
        check("first_instr", if_instr, 32'h13);
        check("first_req_addr", req_log[0], 32'h0);

        // Decode stall: no request, held output stable; release issues addr 4
        if_ready = 1'b0;
        n0 = req_log.size();
        for (int i = 0; i < 3; i++) step();
        check("stall_noreq", req_log.size(), n0);
        check("stall_pc", if_pc, 32'h0);
        if_ready = 1'b1;
        step();
        check("resume_issued", req_log.size(), n0 + 1);
        if (req_log.size() > n0) check("resume_addr", req_log[req_log.size() - 1], 32'h4);
        step();

        // Redirect while waiting; response two cycles later is dropped
        mem_lat = 3;
        wait_req("pre_redir_addr", 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        mem_lat        = 1;
        step();
        step();
        check("drop_vld", if_valid, 1'b0);
        wait_req("redir_addr", 32'h100);

        // Redirect coinciding with the response
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        check("coinc_vld", if_valid, 1'b0);
        wait_req("coinc_addr", 32'h200);
        step();

        // Redirect flushes a held instruction even with if_ready high
        if_ready = 1'b0;
        step();
        check("held_vld", if_valid, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        if_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("flush_vld", if_valid, 1'b0);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_req("wrap_pre_addr", 32'hFFFF_FFFC);
        wait_req("wrap_addr", 32'h0);
        check("wrap_ifpc", if_pc, 32'hFFFF_FFFC);

        // Reset while waiting; the late response must be ignored
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        step();
        redirect_valid = 1'b0;
        mem_lat        = 3;
        wait_req("pre_rst_addr", 32'h400);
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        mem_lat = 1;
        wait_req("rst_addr", RPC);
        check("rst_vld", if_valid, 1'b0);
        step();
        step();

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign_flag", fetch_misalign, 1'b1);
        n0 = req_log.size();
        for (int i = 0; i < 10; i++) step();
        check("halt_noreq", req_log.size(), n0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`else
        wait_req("misalign_addr", 32'h100);
`endif

        // Randomized traffic
        data_const = 1'b0;
        spur_en    = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 399) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            redirect_pc[1:0] = 2'b00;
`endif
            if_ready       = ($urandom_range(0, 9) < 7);
            imem_req_ready = ($urandom_range(0, 9) < 6);
            mem_lat        = $urandom_range(1, 4);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
